// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM state type and index-to-one-hot helper for the
// round-robin mux select arbiter.
package mux_arb_pkg;
  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {IDLE, GRANT} state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first unmasked request after ptr,
// searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [NREQ-1:0]  mask_bit,
  output logic [SEL_W-1:0] win_idx,
  output logic             win_vld
);

  logic [NREQ-1:0]  cand;
  logic [SEL_W-1:0] idx;

  // Scan from lowest to highest priority so the nearest candidate wins last.
  always_comb begin
    cand    = req & ~mask_bit;
    win_idx = ptr;
    win_vld = 1'b0;
    idx     = ptr;
    for (int k = NREQ; k >= 1; k--) begin
      idx = ptr + SEL_W'(k);
      if (cand[idx]) begin
        win_idx = idx;
        win_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of the 4:1 mux stage.
// Optional grant watchdog compiled in with MUX_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; sel holds the previous owner
// GRANT | owner in sel holds the mux path until release
module mux_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             gnt_vld,
  output logic             tmo
);

  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
    $error("MAX_HOLD out of range 2..256");
  end

  state_t           state;
  logic [SEL_W-1:0] last;
  logic [NREQ-1:0]  mask_bit;
  logic [SEL_W-1:0] win_idx;
  logic             win_vld;
  logic             tmo_fire;
  logic             rel;

`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0] hold;
  assign tmo_fire = (state == GRANT) && (hold == 8'(MAX_HOLD - 1));
`else
  assign tmo_fire = 1'b0;
  assign tmo      = 1'b0;
`endif

  assign rel      = done || !req[sel] || tmo_fire;
  assign mask_bit = ((state == GRANT) && (done || tmo_fire)) ? onehot(sel) : '0;

  rr_pick4 u_pick (
    .req      (req),
    .ptr      (last),
    .mask_bit (mask_bit),
    .win_idx  (win_idx),
    .win_vld  (win_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 2'b11;
      sel     <= '0;
      gnt     <= '0;
      gnt_vld <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      hold    <= '0;
      tmo     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state   <= GRANT;
            sel     <= win_idx;
            last    <= win_idx;
            gnt     <= onehot(win_idx);
            gnt_vld <= 1'b1;
          end
        end
        GRANT: begin
          if (rel) begin
            if (win_vld) begin
              sel  <= win_idx;
              last <= win_idx;
              gnt  <= onehot(win_idx);
            end else begin
              state   <= IDLE;
              gnt     <= '0;
              gnt_vld <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
`ifdef MUX_ARB_TIMEOUT_EN
      tmo <= tmo_fire;
      // Handoff restarts the count for the new owner.
      if (state == IDLE || rel) hold <= '0;
      else                      hold <= hold + 8'd1;
`endif
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter; timeout checks follow MUX_ARB_TIMEOUT_EN.
module tb_mux_sel_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       gnt_vld;
  logic       tmo;

  int n_cmp = 0;
  int n_err = 0;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  mux_sel_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .gnt_vld (gnt_vld),
    .tmo     (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_owner(input string tag, input int idx);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    chk({tag, "_gnt"}, 8'(gnt), 8'(oh));
    chk({tag, "_sel"}, 8'(sel), 8'(idx));
    chk({tag, "_vld"}, 8'(gnt_vld), 8'd1);
  endtask

  task automatic chk_idle(input string tag, input int last_idx);
    chk({tag, "_gnt"}, 8'(gnt), 8'd0);
    chk({tag, "_sel"}, 8'(sel), 8'(last_idx));
    chk({tag, "_vld"}, 8'(gnt_vld), 8'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq [4];
    seq = '{1, 2, 3, 0};
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    step();
    step();
    chk_idle("reset", 0);
    chk("reset_tmo", 8'(tmo), 8'd0);
    rst = 1'b0;

    // first grant, one cycle latency
    req = 4'b0001;
    step();
    chk_owner("first", 0);

    // full rotation with done every third cycle, no idle gaps
    req = 4'b1111;
    foreach (seq[i]) begin
      done = 1'b1;
      step();
      done = 1'b0;
      chk_owner($sformatf("rot%0d_a", i), seq[i]);
      chk($sformatf("rot%0d_tmo", i), 8'(tmo), 8'd0);
      step();
      chk_owner($sformatf("rot%0d_b", i), seq[i]);
      step();
      chk_owner($sformatf("rot%0d_c", i), seq[i]);
    end

    // owner 0 drops request; sole requester 2 takes over directly
    req = 4'b0100;
    step();
    chk_owner("drop_to2", 2);
    done = 1'b1;
    step();
    chk_idle("done_idle", 2);
    req = 4'b0000;
    step();
    chk_idle("done_in_idle", 2);
    done = 1'b0;
    req  = 4'b0101;
    step();
    chk_owner("rr_after_idle", 0);

    // watchdog on owner 1
    req = 4'b0010;
    step();
    chk_owner("own1", 1);
    req = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_owner($sformatf("own1_hold%0d", i), 1);
      chk($sformatf("own1_tmo%0d", i), 8'(tmo), 8'd0);
    end
    step();
    if (TMO_EN) begin
      chk_owner("tmo_handoff", 2);
      chk("tmo_pulse", 8'(tmo), 8'd1);
      step();
      chk("tmo_one_cycle", 8'(tmo), 8'd0);
      chk_owner("tmo_after", 2);
    end else begin
      for (int i = 0; i < 8; i++) step();
      chk_owner("no_tmo_hold", 1);
      chk("no_tmo_pulse", 8'(tmo), 8'd0);
    end

    // async reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk_idle("async_rst", 0);
    chk("async_rst_tmo", 8'(tmo), 8'd0);
    req = 4'b1000;
    step();
    rst = 1'b0;
    step();
    chk_owner("post_rst", 3);

    // done coinciding with timeout: one handoff, one pulse
    req = 4'b0001;
    step();
    chk_owner("own0", 0);
    req = 4'b0011;
    step();
    step();
    step();
    chk_owner("own0_held", 0);
    done = 1'b1;
    step();
    done = 1'b0;
    chk_owner("both_handoff", 1);
    chk("both_tmo", 8'(tmo), TMO_EN ? 8'd1 : 8'd0);
    step();
    chk_owner("both_after", 1);
    chk("both_tmo_clear", 8'(tmo), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Round-robin arbiter that sits directly upstream of the 4-to-1 multiplexer stage and drives its 2-bit `sel` input. Four requesters compete for the shared mux path. The arbiter grants one requester at a time, holds `sel` stable for the whole grant, and re-arbitrates fairly when the owner releases. An optional watchdog forcibly ends grants that are held too long.

## Interface
Parameters:
- `MAX_HOLD`, default 16: maximum grant length in cycles when the timeout feature is compiled in; legal range 2..256.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `req`  in  4: request vector; `req[i]` high means requester i wants the mux path.
- `done`  in  1: current owner releases its grant; ignored when no grant is active.
- `gnt`  out  4: one-hot grant, or all-zero when idle.
- `sel`  out  2: mux select; equals the index of the current owner.
- `gnt_vld`  out  1: a grant is active.
- `tmo`  out  1: one-cycle pulse when the watchdog forces a release.

## Operation
- FSM has two states, IDLE and GRANT. It is encoded in `state_t`.
- Round-robin pointer `last` (2 bits) holds the index of the most recent owner.
  - Search order starts at `last+1` and wraps modulo 4.
  - The first set `req` bit in that order wins.
- IDLE:
  - If `req` is nonzero, load owner = winner, update `last`, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT: a release occurs when any of the following is true:
  - `done` is high,
  - `req[owner]` is low,
  - the timeout fires.
- On release:
  - Recompute the winner from `req`, excluding the owner bit when `done` or timeout caused the release. The owner re-wins only if it is the sole requester and the release was caused by `req` dropping, which cannot happen, so in practice the owner bit is always excluded.
  - If a winner exists, hand off directly: stay in GRANT with the new owner. There is no bubble cycle.
  - If no winner exists, go to IDLE.
- Changes on non-owner `req` bits during a grant have no effect until the next release.
- `sel` holds the last owner while idle, so the downstream mux output stays stable.
- `gnt` = one-hot(`sel`) when `gnt_vld` is high, else 0.

## Timing
- Reset values: `gnt`=4'b0000, `sel`=2'b00, `gnt_vld`=0, `tmo`=0, `last`=2'b11 (so requester 0 has first priority), state IDLE, hold counter 0.
- All outputs are registered. `req` sampled at edge N produces a grant visible after edge N (latency 1 cycle).
- Release sampled at edge N: the new owner, or idle, is visible after edge N. Handoff never inserts an idle cycle.
- `done` together with timeout in the same cycle counts as one release; `tmo` still pulses.
- `done` while in IDLE has no effect.
- Reset asserted mid-grant clears every output asynchronously. The first grant after reset follows the reset-value priority.

## Configuration
- Macro: `MUX_ARB_TIMEOUT_EN`.
- Defined:
  - An 8-bit hold counter clears on each new grant and increments each cycle in GRANT.
  - When the count reaches `MAX_HOLD-1` with no other release, the grant is forcibly released on that edge and `tmo` pulses for one cycle.
- Undefined:
  - No counter logic exists, `tmo` is tied to 0, and `MAX_HOLD` is unused.
  - Grants last until `done` or until `req[owner]` drops.

## Structure
- Package `mux_arb_pkg` contains:
  - `localparam NREQ = 4` and `SEL_W = 2`,
  - `typedef enum logic {IDLE, GRANT} state_t`,
  - the one-hot conversion function.
- Sub-module `rr_pick4`: combinational. It takes `req[3:0]`, `ptr[1:0]` and `mask_bit[3:0]` and produces `win_idx[1:0]` and `win_vld`. It is instantiated once by the top FSM.

## Test plan
- Reset, then `req`=4'b0001 → one cycle later `gnt`=0001, `sel`=00, `gnt_vld`=1.
- `req`=4'b1111 held with `done` pulsed every 3 cycles → owners cycle 0,1,2,3,0 with no idle cycle between grants.
- Owner 2 active, `req`=4'b0100, `done` pulsed → `gnt_vld`=0 next cycle and `sel` stays 10. A later `req`=4'b0101 grants requester 0.
- Owner 1 with `req[1]` held high, no `done`, macro defined, `MAX_HOLD`=4 → `tmo` pulses on the 4th grant cycle and the grant passes to the next requester. With the macro undefined, the grant holds indefinitely.
- `rst` asserted asynchronously mid-grant between clock edges → all outputs read 0 immediately. After release, `req`=4'b1000 grants requester 3.
- `done` and timeout in the same cycle with `req`=4'b0011 and owner 0 → a single handoff to owner 1 and exactly one `tmo` pulse.
